lap_timer: RTL and testbench
============================

# lap_timer

Parametrised BCD stopwatch/countdown core with lap-freeze, preset load and expiry detection; the next-generation counting engine behind the 7-segment stopwatch, replacing ad-hoc digit counters in the top level. It accepts single-cycle command pulses (already debounced and edge-detected by the caller) and produces a packed BCD count plus a separately frozen display value for the segment driver. The internal prescaler derives the tick from the system clock; no external timer instance is needed.

## Interface

- CLOCK_HZ, 12_000_000, system clock frequency; must be divisible by 10**SUBSEC_DIGITS.
- SUBSEC_DIGITS, 1, fractional-second digits (1 = tenths, 2 = hundredths); legal 1..2.
- MIN_DIGITS, 1, minute digits (1 = 0-9 min, 2 = 0-99 min); legal 1..2.
- Derived: NUM_DIGITS = SUBSEC_DIGITS+2+MIN_DIGITS; W = 4*NUM_DIGITS; PRESCALE = CLOCK_HZ/10**SUBSEC_DIGITS.
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start_stop  input  1  pulse; toggles run state.
- clear  input  1  pulse; zeroes count and prescaler (not while running).
- lap  input  1  pulse; captures/releases lap display.
- mode_down  input  1  level; 1 = count down, sampled only on a start.
- load_valid  input  1  pulse; loads load_bcd into count (only while STOPPED).
- load_bcd  input  W  preset, packed BCD, same layout as count_bcd.
- count_bcd  output  W  live count; nibble 0 = least-significant fractional digit, top nibble = most-significant minute digit.
- display_bcd  output  W  count_bcd, or frozen lap value while lap_active.
- running  output  1  state == S_RUNNING.
- lap_active  output  1  display frozen.
- wrapped  output  1  one-cycle pulse: up-count rolled from all-max to zero.
- expired  output  1  one-cycle pulse: down-count reached zero.

## Operation

- Digit radices (LSB up): fractional digits 10, seconds units 10, seconds tens 6, minute digits 10. Max value e.g. 9:59.9 = 16'h9599 for defaults.
- States: S_STOPPED, S_RUNNING, S_EXPIRED.
- S_STOPPED: start_stop -> S_RUNNING, latch dir = mode_down; if mode_down=1 and count==0, start ignored. clear -> count=0, prescaler=0, lap_active=0. load_valid -> count = load_bcd with each digit clamped to its radix max (nibble > max becomes max). lap -> lap_active=0.
- S_RUNNING: prescaler increments each cycle; at PRESCALE-1 it returns to 0 and a tick updates count by ±1 with BCD carry/borrow across all digits. start_stop -> S_STOPPED (prescaler held, not cleared). clear, load_valid, mode_down changes ignored. lap -> lap_active=1, lap register = current count_bcd (re-capture on every lap pulse).
- Up wrap: all-max + 1 -> 0, wrapped=1 one cycle, keep running.
- Down: tick at count==1 LSB -> count=0, expired=1 one cycle, state -> S_EXPIRED, running=0.
- S_EXPIRED: start_stop, lap, load_valid ignored; clear -> zero everything, S_STOPPED.
- Priority in one cycle: reset_n > clear > load_valid > start_stop > lap.
- Tick coincident with stop pulse: tick applied, then stop. Tick coincident with lap: lap captures pre-tick count.
- Reset values (reset_n low at an edge): state S_STOPPED, count_bcd 0, display_bcd 0, prescaler 0, dir 0, running 0, lap_active 0, wrapped 0, expired 0. Reset mid-run aborts immediately.

## Timing

- All outputs registered; commands take effect at the edge where the pulse is sampled; running rises the cycle after start_stop.
- With prescaler 0 at start edge t0, first count change at edge t0+PRESCALE; subsequent every PRESCALE cycles while running.
- Pause/resume: remaining fraction preserved; next tick after PRESCALE minus cycles already accumulated.
- wrapped/expired asserted in the same cycle count_bcd shows the new value.
- display_bcd follows count_bcd with zero added latency when lap_active=0.

## Test plan

Parameters CLOCK_HZ=100, SUBSEC_DIGITS=1, MIN_DIGITS=1 (PRESCALE=10, W=16).
- Count up: reset, start_stop, run 1000 cycles -> count_bcd=16'h0100 (0:10.0), running=1; stop -> value holds for 100 cycles.
- Wrap: load 16'h9599, start up -> after 10 cycles count_bcd=16'h0000, wrapped pulses exactly 1 cycle, running stays 1.
- Countdown: load 16'h0002, mode_down=1, start -> 16'h0001 at +10, 16'h0000 at +20 with expired pulse, state S_EXPIRED; start_stop ignored; clear -> S_STOPPED; start with count 0 in down mode ignored.
- Lap: start, lap at count 16'h0005 -> display_bcd=16'h0005, lap_active=1 while count reaches 16'h0008 after 30 more cycles; stop, lap -> display_bcd=count_bcd.
- Load clamp and pause fraction: load 16'h0A70 -> count 16'h0570; start, stop after 5 cycles, restart -> increment after exactly 5 further running cycles.
- Reset/priority: reset_n low one cycle mid-run -> all outputs zero next cycle; clear+load+start same cycle while stopped -> only clear takes effect.

Source files
------------

// File: rtl/lap_timer.sv
// lap_timer: BCD stopwatch / countdown engine.
// Counts in mixed-radix BCD (fraction digits, seconds 0-59, minutes) from a
// prescaled system clock, supports pause with preserved fraction, preset load
// with per-digit clamping, lap freeze of the display and wrap/expiry pulses.
module lap_timer #(
  parameter int CLOCK_HZ      = 12_000_000,
  parameter int SUBSEC_DIGITS = 1,
  parameter int MIN_DIGITS    = 1
) (
  input  logic                                        i_clock,
  input  logic                                        i_reset_n,
  input  logic                                        i_start_stop,
  input  logic                                        i_clear,
  input  logic                                        i_lap,
  input  logic                                        i_mode_down,
  input  logic                                        i_load_valid,
  input  logic [4*(SUBSEC_DIGITS+2+MIN_DIGITS)-1:0]   i_load_bcd,
  output logic [4*(SUBSEC_DIGITS+2+MIN_DIGITS)-1:0]   o_count_bcd,
  output logic [4*(SUBSEC_DIGITS+2+MIN_DIGITS)-1:0]   o_display_bcd,
  output logic                                        o_running,
  output logic                                        o_lap_active,
  output logic                                        o_wrapped,
  output logic                                        o_expired
);

  localparam int NUM_DIGITS = SUBSEC_DIGITS + 2 + MIN_DIGITS;
  localparam int W          = 4 * NUM_DIGITS;
  localparam int PRESCALE   = CLOCK_HZ / (10 ** SUBSEC_DIGITS);
  localparam int PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    S_STOPPED = 2'd0,
    S_RUNNING = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  // Largest legal value of digit idx: the seconds-tens digit is base 6.
  function automatic logic [3:0] digit_max(input int idx);
    logic [3:0] m;
    if (idx == SUBSEC_DIGITS + 1) m = 4'd5;
    else                          m = 4'd9;
    return m;
  endfunction

  // Mixed-radix increment; MSB of the result is the carry out of the top digit.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == digit_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {c, r};
  endfunction

  // Mixed-radix decrement; only used with a non-zero operand.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = digit_max(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Saturate every nibble of a preset to its digit's radix maximum.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
      else                            r[4*i +: 4] = v[4*i +: 4];
    end
    return r;
  endfunction

  state_t          r_state, w_state;
  logic [W-1:0]    r_count, w_count;
  logic [W-1:0]    r_lap_val, w_lap_val;
  logic [W-1:0]    r_display, w_display;
  logic [PW-1:0]   r_presc, w_presc;
  logic            r_dir, w_dir;
  logic            r_lap_active, w_lap_active;
  logic            r_wrapped, w_wrapped;
  logic            r_expired, w_expired;
  logic            r_running;
  logic [W:0]      w_inc;
  logic [W-1:0]    w_dec;
  logic            w_tick;

  assign w_inc  = bcd_inc(r_count);
  assign w_dec  = bcd_dec(r_count);
  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  // Next-state and next-output decode; commands are prioritised clear > load > start_stop > lap.
  always_comb begin
    w_state      = r_state;
    w_count      = r_count;
    w_lap_val    = r_lap_val;
    w_presc      = r_presc;
    w_dir        = r_dir;
    w_lap_active = r_lap_active;
    w_wrapped    = 1'b0;
    w_expired    = 1'b0;
    case (r_state)
      S_STOPPED: begin
        if (i_clear) begin
          w_count      = {W{1'b0}};
          w_presc      = {PW{1'b0}};
          w_lap_active = 1'b0;
        end else if (i_load_valid) begin
          w_count = bcd_clamp(i_load_bcd);
        end else if (i_start_stop) begin
          // A countdown from zero has nothing to count, so the start is dropped.
          if (!(i_mode_down && (r_count == {W{1'b0}}))) begin
            w_state = S_RUNNING;
            w_dir   = i_mode_down;
          end else begin
            w_state = S_STOPPED;
          end
        end else if (i_lap) begin
          w_lap_active = 1'b0;
        end else begin
          w_state = S_STOPPED;
        end
      end
      S_RUNNING: begin
        if (w_tick) begin
          w_presc = {PW{1'b0}};
          if (r_dir) begin
            w_count   = w_dec;
            w_expired = (w_dec == {W{1'b0}});
          end else begin
            w_count   = w_inc[W-1:0];
            w_wrapped = w_inc[W];
          end
        end else begin
          w_presc = r_presc + PW'(1);
        end
        // The tick is applied first; a coincident stop or lap acts on top of it.
        if (w_expired) begin
          w_state = S_EXPIRED;
        end else if (i_start_stop) begin
          w_state = S_STOPPED;
        end else if (i_lap) begin
          w_lap_active = 1'b1;
          w_lap_val    = r_count;
        end else begin
          w_state = S_RUNNING;
        end
      end
      S_EXPIRED: begin
        if (i_clear) begin
          w_state      = S_STOPPED;
          w_count      = {W{1'b0}};
          w_presc      = {PW{1'b0}};
          w_dir        = 1'b0;
          w_lap_active = 1'b0;
        end else begin
          w_state = S_EXPIRED;
        end
      end
      default: begin
        w_state = S_STOPPED;
      end
    endcase
    w_display = w_lap_active ? w_lap_val : w_count;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state      <= S_STOPPED;
      r_count      <= {W{1'b0}};
      r_lap_val    <= {W{1'b0}};
      r_display    <= {W{1'b0}};
      r_presc      <= {PW{1'b0}};
      r_dir        <= 1'b0;
      r_lap_active <= 1'b0;
      r_wrapped    <= 1'b0;
      r_expired    <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_count      <= w_count;
      r_lap_val    <= w_lap_val;
      r_display    <= w_display;
      r_presc      <= w_presc;
      r_dir        <= w_dir;
      r_lap_active <= w_lap_active;
      r_wrapped    <= w_wrapped;
      r_expired    <= w_expired;
      r_running    <= (w_state == S_RUNNING);
    end
  end

  assign o_count_bcd   = r_count;
  assign o_display_bcd = r_display;
  assign o_running     = r_running;
  assign o_lap_active  = r_lap_active;
  assign o_wrapped     = r_wrapped;
  assign o_expired     = r_expired;

endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: directed tables, hand sequences and random stimulus for
// lap_timer, checked every cycle against a model that keeps time as a plain
// integer count of tenths of a second (CLOCK_HZ=100, 1 fraction digit, 1 minute digit).
module tb_lap_timer;

  localparam int P      = 10;     // cycles per tenth
  localparam int MAXVAL = 5999;   // 9:59.9 in tenths

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_start_stop = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_lap = 1'b0;
  logic        i_mode_down = 1'b0;
  logic        i_load_valid = 1'b0;
  logic [15:0] i_load_bcd = 16'h0000;
  logic [15:0] o_count_bcd;
  logic [15:0] o_display_bcd;
  logic        o_running, o_lap_active, o_wrapped, o_expired;

  int n_vec  = 0;
  int n_fail = 0;

  lap_timer #(.CLOCK_HZ(100), .SUBSEC_DIGITS(1), .MIN_DIGITS(1)) dut (
    .i_clock(clk), .i_reset_n(i_reset_n), .i_start_stop(i_start_stop),
    .i_clear(i_clear), .i_lap(i_lap), .i_mode_down(i_mode_down),
    .i_load_valid(i_load_valid), .i_load_bcd(i_load_bcd),
    .o_count_bcd(o_count_bcd), .o_display_bcd(o_display_bcd),
    .o_running(o_running), .o_lap_active(o_lap_active),
    .o_wrapped(o_wrapped), .o_expired(o_expired)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 counting, 2 timed out; values in tenths.
  int m_mode = 0, m_val = 0, m_presc = 0, m_dir = 0;
  int m_lap_act = 0, m_lap_val = 0, m_wrap = 0, m_exp = 0;

  function automatic logic [15:0] to_bcd(input int v);
    int f, s, m;
    logic [15:0] r;
    f = v % 10;
    s = (v / 10) % 60;
    m = v / 600;
    r = 16'(m * 4096 + (s / 10) * 256 + (s % 10) * 16 + f);
    return r;
  endfunction

  function automatic int clamp_units(input logic [15:0] b);
    int d0, d1, d2, d3;
    d0 = (b[3:0]   > 4'd9) ? 9 : int'(b[3:0]);
    d1 = (b[7:4]   > 4'd9) ? 9 : int'(b[7:4]);
    d2 = (b[11:8]  > 4'd5) ? 5 : int'(b[11:8]);
    d3 = (b[15:12] > 4'd9) ? 9 : int'(b[15:12]);
    return d0 + 10 * d1 + 100 * d2 + 600 * d3;
  endfunction

  task automatic model_step();
    int pre;
    m_wrap = 0;
    m_exp  = 0;
    if (!i_reset_n) begin
      m_mode = 0; m_val = 0; m_presc = 0; m_dir = 0; m_lap_act = 0; m_lap_val = 0;
    end else if (m_mode == 0) begin
      if (i_clear) begin
        m_val = 0; m_presc = 0; m_lap_act = 0;
      end else if (i_load_valid) begin
        m_val = clamp_units(i_load_bcd);
      end else if (i_start_stop) begin
        if (!(i_mode_down && m_val == 0)) begin
          m_mode = 1; m_dir = int'(i_mode_down);
        end
      end else if (i_lap) begin
        m_lap_act = 0;
      end
    end else if (m_mode == 1) begin
      pre = m_val;
      m_presc = m_presc + 1;
      if (m_presc == P) begin
        m_presc = 0;
        if (m_dir != 0) begin
          m_val = m_val - 1;
          if (m_val == 0) m_exp = 1;
        end else if (m_val == MAXVAL) begin
          m_val = 0; m_wrap = 1;
        end else begin
          m_val = m_val + 1;
        end
      end
      if (m_exp != 0) m_mode = 2;
      else if (i_start_stop) m_mode = 0;
      else if (i_lap) begin
        m_lap_act = 1; m_lap_val = pre;
      end
    end else begin
      if (i_clear) begin
        m_mode = 0; m_val = 0; m_presc = 0; m_lap_act = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [15:0] e_cnt, e_disp;
    logic [3:0]  e_flags, a_flags;
    e_cnt   = to_bcd(m_val);
    e_disp  = (m_lap_act != 0) ? to_bcd(m_lap_val) : e_cnt;
    e_flags = {(m_mode == 1), (m_lap_act != 0), (m_wrap != 0), (m_exp != 0)};
    a_flags = {o_running, o_lap_active, o_wrapped, o_expired};
    n_vec++;
    if (o_count_bcd !== e_cnt || o_display_bcd !== e_disp || a_flags !== e_flags) begin
      n_fail++;
      $display("FAIL model t=%0t got cnt=%h disp=%h run/lap/wrap/exp=%b expected cnt=%h disp=%h run/lap/wrap/exp=%b",
               $time, o_count_bcd, o_display_bcd, a_flags, e_cnt, e_disp, e_flags);
    end
  endtask

  task automatic expect16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: update DUT and model, check away from the edge, drop pulses.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    i_start_stop = 1'b0; i_clear = 1'b0; i_lap = 1'b0;
    i_load_valid = 1'b0; i_reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  typedef struct {
    logic [15:0] load;
    logic [15:0] exp;
  } load_vec_t;

  load_vec_t lv_tab[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lv_tab[0] = '{16'h0A70, 16'h0570};
    lv_tab[1] = '{16'hFFFF, 16'h9599};
    lv_tab[2] = '{16'h1234, 16'h1234};
    lv_tab[3] = '{16'h0F0F, 16'h0509};
    lv_tab[4] = '{16'h9599, 16'h9599};
    lv_tab[5] = '{16'h7C3B, 16'h7539};

    // Reset state
    i_reset_n = 1'b0;
    #2;
    cyc();
    i_reset_n = 1'b0;
    cyc();
    expect16("reset_count", o_count_bcd, 16'h0000);
    expect16("reset_flags", {12'h000, o_running, o_lap_active, o_wrapped, o_expired}, 16'h0000);

    // Load clamp table
    for (int i = 0; i < 6; i++) begin
      i_clear = 1'b1; cyc();
      i_load_valid = 1'b1; i_load_bcd = lv_tab[i].load; cyc();
      expect16("load_clamp", o_count_bcd, lv_tab[i].exp);
    end

    // Count up 1000 cycles, then stop and hold
    i_clear = 1'b1; cyc();
    i_mode_down = 1'b0; i_start_stop = 1'b1; cyc();
    idle(1000);
    expect16("up_1000", o_count_bcd, 16'h0100);
    expect16("up_running", {15'h0000, o_running}, 16'h0001);
    i_start_stop = 1'b1; cyc();
    idle(100);
    expect16("stop_hold", o_count_bcd, 16'h0100);
    expect16("stop_running", {15'h0000, o_running}, 16'h0000);

    // Wrap from all-max
    i_clear = 1'b1; cyc();
    i_load_valid = 1'b1; i_load_bcd = 16'h9599; cyc();
    i_start_stop = 1'b1; cyc();
    idle(9);
    expect16("wrap_pre", o_count_bcd, 16'h9599);
    cyc();
    expect16("wrap_count", o_count_bcd, 16'h0000);
    expect16("wrap_pulse", {14'h0000, o_running, o_wrapped}, 16'h0003);
    cyc();
    expect16("wrap_after", {14'h0000, o_running, o_wrapped}, 16'h0002);

    // Countdown to expiry
    i_start_stop = 1'b1; cyc();
    i_clear = 1'b1; cyc();
    i_load_valid = 1'b1; i_load_bcd = 16'h0002; cyc();
    i_mode_down = 1'b1; i_start_stop = 1'b1; cyc();
    idle(10);
    expect16("down_1", o_count_bcd, 16'h0001);
    idle(10);
    expect16("down_0", o_count_bcd, 16'h0000);
    expect16("down_exp", {14'h0000, o_running, o_expired}, 16'h0001);
    cyc();
    expect16("exp_pulse_end", {15'h0000, o_expired}, 16'h0000);
    i_start_stop = 1'b1; cyc();
    cyc();
    expect16("exp_start_ignored", {15'h0000, o_running}, 16'h0000);
    i_clear = 1'b1; cyc();
    i_start_stop = 1'b1; cyc();
    cyc();
    expect16("down_zero_start", {15'h0000, o_running}, 16'h0000);
    i_mode_down = 1'b0;

    // Lap freeze and release
    i_clear = 1'b1; cyc();
    i_start_stop = 1'b1; cyc();
    idle(50);
    expect16("lap_pre", o_count_bcd, 16'h0005);
    i_lap = 1'b1; cyc();
    expect16("lap_disp", o_display_bcd, 16'h0005);
    idle(30);
    expect16("lap_count", o_count_bcd, 16'h0008);
    expect16("lap_frozen", o_display_bcd, 16'h0005);
    expect16("lap_active", {15'h0000, o_lap_active}, 16'h0001);
    i_start_stop = 1'b1; cyc();
    i_lap = 1'b1; cyc();
    expect16("lap_release", o_display_bcd, 16'h0008);

    // Pause keeps the accumulated fraction
    i_clear = 1'b1; cyc();
    i_load_valid = 1'b1; i_load_bcd = 16'h0A70; cyc();
    expect16("clamp_0A70", o_count_bcd, 16'h0570);
    i_start_stop = 1'b1; cyc();
    idle(4);
    i_start_stop = 1'b1; cyc();
    idle(3);
    i_start_stop = 1'b1; cyc();
    idle(4);
    expect16("resume_pre", o_count_bcd, 16'h0570);
    cyc();
    expect16("resume_tick", o_count_bcd, 16'h0571);

    // Reset mid-run, then same-cycle clear+load+start
    i_reset_n = 1'b0; cyc();
    expect16("midrun_reset", {o_count_bcd[11:0], o_running, o_lap_active, o_wrapped, o_expired}, 16'h0000);
    i_load_valid = 1'b1; i_load_bcd = 16'h0123; cyc();
    i_clear = 1'b1; i_load_valid = 1'b1; i_load_bcd = 16'h0456; i_start_stop = 1'b1; cyc();
    expect16("prio_count", o_count_bcd, 16'h0000);
    cyc();
    expect16("prio_running", {15'h0000, o_running}, 16'h0000);

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rv;
      rv = $urandom;
      i_start_stop = ($urandom_range(0, 19) == 0);
      i_clear      = ($urandom_range(0, 59) == 0);
      i_lap        = ($urandom_range(0, 14) == 0);
      i_load_valid = ($urandom_range(0, 24) == 0);
      i_mode_down  = rv[16];
      i_reset_n    = ($urandom_range(0, 699) != 0);
      case (rv[19:17])
        3'd0:    i_load_bcd = 16'h0001;
        3'd1:    i_load_bcd = 16'h0003;
        3'd2:    i_load_bcd = 16'h9597;
        3'd3:    i_load_bcd = 16'h0059;
        default: i_load_bcd = rv[15:0];
      endcase
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
